// File: rtl/i2s_tx_serializer.sv
`timescale 1ns/1ps
// i2s_tx_serializer: stereo PCM sample pairs in over valid/ready,
// Philips-format I2S (BCLK, LRCLK, SDATA) out, one-entry holding buffer.
//
// Ports:
//   clk, reset_n     system clock, async active-low reset
//   enable           transmitter enable (level)
//   clk_div          BCLK half-period minus 1, in clk cycles
//   s_valid/s_ready  sample pair handshake; s_left/s_right samples
//   i2s_bclk         bit clock
//   i2s_lrclk        word select, 0 = left, 1 = right
//   i2s_sdata        serial data, changes on BCLK falling edge
//   underrun         one-clk pulse: frame started with no sample
//
// Optional macro I2S_TX_UNDERRUN_CNT_EN adds:
//   underrun_clr     clears the underrun counter
//   underrun_cnt     saturating 16-bit count of underrun pulses
module i2s_tx_serializer #(
  parameter int DATA_W = 16,
  parameter int SLOT_W = 32,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              i2s_bclk,
  output logic              i2s_lrclk,
  output logic              i2s_sdata,
  output logic              underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  input  logic              underrun_clr,
  output logic [15:0]       underrun_cnt
`endif
);

  localparam int FW = 2 * SLOT_W;
  localparam int BW = $clog2(FW);
  localparam logic [BW-1:0] LAST   = BW'(FW - 1);
  localparam logic [BW-1:0] SLOT_V = BW'(SLOT_W);
  localparam int PAD = SLOT_W - DATA_W;

  logic [DIV_W-1:0]  r_div_cnt;
  logic              r_bclk;
  logic              r_lrclk;
  logic              r_sdata;
  logic              r_underrun;
  logic [BW-1:0]     r_bit_cnt;
  logic [FW-1:0]     r_shift;

  logic              r_buf_full;
  logic              r_ready;
  logic [DATA_W-1:0] r_buf_l;
  logic [DATA_W-1:0] r_buf_r;

  logic              w_tick;
  logic              w_fall;
  logic              w_last;
  logic              w_wrap;
  logic              w_take;
  logic              w_urun;
  logic [BW-1:0]     w_bit_nxt;
  logic [SLOT_W-1:0] w_slot_l;
  logic [SLOT_W-1:0] w_slot_r;
  logic [FW-1:0]     w_load;

  // ">=" keeps the divider from stalling if clk_div shrinks
  assign w_tick = (r_div_cnt >= clk_div);
  assign w_fall = enable & w_tick & r_bclk;
  assign w_last = (r_bit_cnt == LAST);
  assign w_wrap = w_fall & w_last;
  assign w_take = s_valid & r_ready;
  assign w_urun = w_wrap & ~r_buf_full;

  assign w_bit_nxt = w_last ? '0
                   : r_bit_cnt + BW'(1);

  // Samples left-justified in their slots
  assign w_slot_l = SLOT_W'(r_buf_l) << PAD;
  assign w_slot_r = SLOT_W'(r_buf_r) << PAD;
  assign w_load   = {w_slot_l, w_slot_r};

  assign s_ready   = r_ready;
  assign i2s_bclk  = r_bclk;
  assign i2s_lrclk = r_lrclk;
  assign i2s_sdata = r_sdata;
  assign underrun  = r_underrun;

  // Holding buffer: stays alive while the
  // transmitter is disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf_full <= 1'b0;
      r_ready    <= 1'b1;
      r_buf_l    <= '0;
      r_buf_r    <= '0;
    end else begin
      if (w_take) begin
        r_buf_full <= 1'b1;
        r_ready    <= 1'b0;
        r_buf_l    <= s_left;
        r_buf_r    <= s_right;
      end else if (w_wrap && r_buf_full) begin
        r_buf_full <= 1'b0;
        r_ready    <= 1'b1;
      end
    end
  end

  // Clock generation and serializer.
  // r_sdata is the one-BCLK delay flop that
  // places the MSB one bit after LRCLK.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt  <= '0;
      r_bclk     <= 1'b0;
      r_lrclk    <= 1'b0;
      r_sdata    <= 1'b0;
      r_underrun <= 1'b0;
      r_bit_cnt  <= LAST;
      r_shift    <= '0;
    end else if (!enable) begin
      r_div_cnt  <= '0;
      r_bclk     <= 1'b0;
      r_lrclk    <= 1'b0;
      r_sdata    <= 1'b0;
      r_underrun <= 1'b0;
      r_bit_cnt  <= LAST;
      r_shift    <= '0;
    end else begin
      r_underrun <= w_urun;
      if (w_tick) begin
        r_div_cnt <= '0;
        r_bclk    <= ~r_bclk;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
      if (w_fall) begin
        r_bit_cnt <= w_bit_nxt;
        r_lrclk   <= (w_bit_nxt >= SLOT_V);
        r_sdata   <= r_shift[FW-1];
        if (w_last) begin
          r_shift <= r_buf_full ? w_load : '0;
        end else begin
          r_shift <= r_shift << 1;
        end
      end
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] r_urun_cnt;

  assign underrun_cnt = r_urun_cnt;

  // Clear has priority over a same-cycle increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_urun_cnt <= '0;
    end else if (underrun_clr) begin
      r_urun_cnt <= '0;
    end else if (w_urun && (r_urun_cnt != 16'hFFFF)) begin
      r_urun_cnt <= r_urun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_tx_serializer.sv
`timescale 1ns/1ps
// tb_i2s_tx_serializer: directed stimulus with a frame scoreboard
// for the I2S transmit serializer (DATA_W=16, SLOT_W=16).
module tb_i2s_tx_serializer;

  localparam int DW = 16;
  localparam int SW = 16;
  localparam int VW = 8;
  localparam int FB = 2 * SW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [VW-1:0] clk_div = 8'd1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_left = '0;
  logic [DW-1:0] s_right = '0;
  logic          i2s_bclk;
  logic          i2s_lrclk;
  logic          i2s_sdata;
  logic          underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic          underrun_clr = 1'b0;
  logic [15:0]   underrun_cnt;
`endif

  i2s_tx_serializer #(
    .DATA_W(DW),
    .SLOT_W(SW),
    .DIV_W (VW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .clk_div     (clk_div),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_left      (s_left),
    .s_right     (s_right),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_sdata   (i2s_sdata),
    .underrun    (underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .underrun_clr(underrun_clr),
    .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [FB-1:0] exp_q[$];

  bit mon_en = 1'b0;
  int exp_period = 4;
  int c_en = 0;

  int nfall = 0;
  int frames_done = 0;
  int n_ur = 0;
  int first_fall_cyc = 0;
  int last_fall_cyc = 0;
  int frame_start_cyc = 0;
  int frame_len = 0;
  int mon_j = 0;
  logic [FB-1:0] cur_word = '0;
  logic prev_bclk = 1'b0;
  logic prev_ur = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, got, exp);
    end
  endtask

  // Frame monitor: tracks BCLK falls to know the bit slot,
  // samples SDATA on BCLK rises, rebuilds {left,right} words.
  always @(negedge clk) begin
    if (underrun) begin
      n_ur++;
      check("ur_width", prev_ur, 0);
    end
    prev_ur = underrun;
    if (!mon_en) begin
      nfall = 0;
      prev_bclk = 1'b0;
      cur_word = '0;
    end else begin
      if (prev_bclk && !i2s_bclk) begin
        mon_j = nfall % FB;
        if (nfall == 0)
          first_fall_cyc = cyc;
        else
          check("bclk_period", cyc - last_fall_cyc,
                exp_period);
        if (mon_j == 0) begin
          if (nfall > 0) frame_len = cyc - frame_start_cyc;
          frame_start_cyc = cyc;
        end
        last_fall_cyc = cyc;
        check("lrclk", i2s_lrclk, mon_j >= SW);
        nfall++;
      end else if (!prev_bclk && i2s_bclk && nfall > 0) begin
        mon_j = (nfall - 1) % FB;
        if (nfall == 1) begin
          check("sdata_lead", i2s_sdata, 0);
        end else if (mon_j == 0) begin
          cur_word[0] = i2s_sdata;
          check("frame_q", exp_q.size() != 0, 1);
          if (exp_q.size() != 0)
            check("frame", cur_word, exp_q.pop_front());
          frames_done++;
          cur_word = '0;
        end else begin
          cur_word[FB-mon_j] = i2s_sdata;
        end
      end
      prev_bclk = i2s_bclk;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    enable = 1'b1;
    mon_en = 1'b1;
    c_en = cyc;
  endtask

  task automatic stop();
    enable = 1'b0;
    mon_en = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] l,
                      input logic [DW-1:0] r,
                      output int acc);
    int t;
    t = 0;
    s_left = l;
    s_right = r;
    s_valid = 1'b1;
    while (!s_ready && t < 2000) begin
      tick();
      t++;
    end
    check("send_timeout", s_ready, 1);
    tick();
    acc = cyc;
    s_valid = 1'b0;
    exp_q.push_back({l, r});
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (frames_done < n && t < 20000) begin
      tick();
      t++;
    end
    check("wait_frames", frames_done >= n, 1);
  endtask

  task automatic wait_falls(input int n);
    int t;
    t = 0;
    while (nfall < n && t < 2000) begin
      tick();
      t++;
    end
    check("wait_falls", nfall >= n, 1);
  endtask

  initial begin
    int acc;
    int bad;
    int u0;
    int f0;

    // Reset state and idle quiet
    tick();
    tick();
    check("rst_ready", s_ready, 1);
    check("rst_bclk", i2s_bclk, 0);
    check("rst_lrclk", i2s_lrclk, 0);
    check("rst_sdata", i2s_sdata, 0);
    check("rst_urun", underrun, 0);
    reset_n = 1'b1;
    bad = 0;
    repeat (100) begin
      tick();
      if (i2s_bclk || i2s_lrclk || i2s_sdata || underrun)
        bad++;
    end
    check("idle_quiet", bad, 0);
    check("idle_ready", s_ready, 1);

    // One pair, then starve: second frame is silent
    clk_div = 8'd1;
    exp_period = 4;
    send(16'hA5C3, 16'h1234, acc);
    check("ready_drop", s_ready, 0);
    u0 = n_ur;
    f0 = frames_done;
    start();
    wait_falls(1);
    check("first_fall", first_fall_cyc - c_en, 4);
    check("ready_back", s_ready, 1);
    exp_q.push_back('0);
    wait_frames(f0 + 2);
    check("urun_t2", n_ur - u0, 2);
    stop();
    tick();
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("urun_cnt", underrun_cnt, 2);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check("urun_clr", underrun_cnt, 0);
`endif
    repeat (5) tick();

    // Three pairs back to back
    send(16'h8001, 16'h7FFE, acc);
    u0 = n_ur;
    f0 = frames_done;
    start();
    send(16'h0F0F, 16'hF0F0, acc);
    check("acc_pair2", acc - c_en, 5);
    send(16'hDEAD, 16'hBEEF, acc);
    check("acc_pair3", acc - c_en, 4 * 33 + 1);
    wait_frames(f0 + 3);
    check("urun_t3", n_ur - u0, 1);
    stop();
    repeat (5) tick();

    // Abort mid-frame with a pair buffered
    send(16'hFFFF, 16'hFFFF, acc);
    start();
    send(16'h3C5A, 16'h9669, acc);
    wait_falls(8);
    bad = 0;
    while (!i2s_bclk && bad < 10) begin
      tick();
      bad++;
    end
    check("pre_bclk", i2s_bclk, 1);
    check("pre_sdata", i2s_sdata, 1);
    stop();
    void'(exp_q.pop_front());
    tick();
    check("off_bclk", i2s_bclk, 0);
    check("off_lrclk", i2s_lrclk, 0);
    check("off_sdata", i2s_sdata, 0);
    check("off_ready", s_ready, 0);
    u0 = n_ur;
    repeat (50) tick();
    check("off_urun", n_ur - u0, 0);
    f0 = frames_done;
    start();
    wait_falls(1);
    check("reen_urun", n_ur - u0, 0);
    check("reen_ready", s_ready, 1);
    wait_frames(f0 + 1);
    check("urun_t4", n_ur - u0, 1);
    stop();
    repeat (5) tick();

    // Fastest divider
    clk_div = 8'd0;
    exp_period = 2;
    tick();
    send(16'h0001, 16'h8000, acc);
    u0 = n_ur;
    f0 = frames_done;
    start();
    wait_falls(1);
    check("first_fall0", first_fall_cyc - c_en, 2);
    send(16'h6B1D, 16'h24E7, acc);
    wait_frames(f0 + 2);
    check("frame_len", frame_len, 64);
    check("urun_t5", n_ur - u0, 1);
    stop();
    repeat (5) tick();
    check("q_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- Downstream stage of the Avalon-MM I2S register slave: accepts stereo PCM sample pairs over a valid/ready handshake and serializes them onto an I2S bus.
- Generates BCLK and LRCLK from clk with a programmable divider. Drives SDATA in standard Philips I2S format: MSB one BCLK after the LRCLK edge, data changing on BCLK falling edge.
- One-entry holding buffer decouples the register slave from frame timing. An underrun is flagged when no sample is ready at a frame boundary.

Parameters:
- DATA_W, 16, sample width per channel in bits.
- SLOT_W, 32, BCLKs per channel slot; must be >= DATA_W.
- DIV_W, 8, width of clk_div.

Ports:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- enable  in  1  transmitter enable, level
- clk_div  in  DIV_W  BCLK half-period minus 1, in clk cycles
- s_valid  in  1  sample pair valid
- s_ready  out  1  holding buffer can accept
- s_left  in  DATA_W  left sample, two's complement
- s_right  in  DATA_W  right sample, two's complement
- i2s_bclk  out  1  bit clock
- i2s_lrclk  out  1  word select; 0 = left, 1 = right
- i2s_sdata  out  1  serial data
- underrun  out  1  one-clk pulse: frame started with no sample

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk. All outputs are registered.
- Reset values:
  - s_ready = 1; i2s_bclk, i2s_lrclk, i2s_sdata, underrun = 0.
  - Holding buffer empty; div_cnt = 0; bit_cnt = 2*SLOT_W-1; shift register and delay flop = 0.
- Divider:
  - While enabled, div_cnt increments each clk. When div_cnt >= clk_div, div_cnt returns to 0 and i2s_bclk toggles.
  - BCLK period = 2*(clk_div+1) clk. clk_div=0 gives clk/2.
  - A ">=" compare is used so that a clk_div decrease while running cannot stall the divider.
  - Software changes clk_div only while enable=0.
- Fall event: a clk cycle in which i2s_bclk toggles 1->0. The first fall comes 2*(clk_div+1) clk after enable rises.
- On each fall event:
  - bit_cnt advances modulo 2*SLOT_W.
  - i2s_lrclk = 0 for new bit_cnt 0..SLOT_W-1, and 1 for SLOT_W..2*SLOT_W-1.
  - The MSB of a 2*SLOT_W shift register moves into the delay flop, which drives i2s_sdata. The shift register shifts left with zero fill.
- Frame load at the fall event where bit_cnt wraps 2*SLOT_W-1 -> 0:
  - If the buffer is full: shift register = {s_left, (SLOT_W-DATA_W) zeros, s_right, (SLOT_W-DATA_W) zeros}, taken from the buffer; buffer empties.
  - If the buffer is empty: shift register = 0 and underrun pulses high for exactly that clk.
- Resulting serial format: left MSB on sdata during bit_cnt=1; right MSB during bit_cnt=SLOT_W+1; right LSB-slot tail during the next frame's bit_cnt=0.
- Handshake:
  - s_ready = !buf_full, registered.
  - A transfer occurs on a clk with s_valid && s_ready. s_left/s_right are captured and buf_full is set.
  - s_ready drops the following clk and reasserts the clk after the frame load empties the buffer.
  - The upstream stage holds s_valid and data stable until accepted.
- enable = 0, including mid-frame, takes effect the next clk:
  - bclk, lrclk, sdata -> 0; div_cnt -> 0; bit_cnt -> 2*SLOT_W-1; shift register and delay flop cleared. The current frame is aborted.
  - The holding buffer and handshake remain operational. A buffered sample is kept and transmitted first after re-enable.
  - No underrun is flagged while disabled.
- reset_n asserted mid-operation: all state returns to reset values immediately, asynchronously. The buffered sample is discarded.

Optional Feature:
- Macro I2S_TX_UNDERRUN_CNT_EN.
- Defined:
  - Adds input underrun_clr (1 bit) and output underrun_cnt (16 bits, reset 0).
  - Counter increments on each underrun pulse and saturates at 0xFFFF.
  - underrun_clr clears it to 0 the next clk; clear wins over a simultaneous increment.
- Undefined: both ports and the counter are absent; underrun pulse behaviour is unchanged.

Test Plan:
- Reset with enable=0 -> s_ready=1; bclk/lrclk/sdata/underrun = 0; they stay 0 for 100 clk.
- DATA_W=16, SLOT_W=16, clk_div=1, push L=0xA5C3, R=0x1234, then enable:
  - BCLK period is 4 clk.
  - lrclk is low for BCLKs 0-15 and high for 16-31.
  - sdata sampled on rising edges: 0, then 1010010111000011, then 0001001000110100 (last bit in next frame's slot 0).
- Push 3 pairs back-to-back with s_valid held -> pair 1 accepted immediately; pair 2 accepted 1 clk after frame-1 load; pair 3 accepted after frame-2 load; frames carry pairs 1, 2, 3 in order.
- One pair then no more data -> second frame boundary: underrun high exactly 1 clk; that frame's sdata is all zeros. With I2S_TX_UNDERRUN_CNT_EN, underrun_cnt=1; underrun_clr -> 0.
- Deassert enable at bit_cnt=7 with a pair buffered -> next clk bclk=lrclk=sdata=0. Re-enable -> buffered pair is sent in the first frame, no underrun.
- clk_div=0 -> BCLK period 2 clk; frame length 2*2*SLOT_W clk = 64 clk for SLOT_W=16.
